uart_loader: RTL and testbench
==============================

# uart_loader

Boot-time program loader sitting directly downstream of the UART receiver. It turns the receiver's toggle-per-byte output into a framed stream: a 16-bit word count, then little-endian 32-bit words written sequentially into instruction memory. The CPU is held in reset while loading is in progress. Any byte arriving after a completed load starts a fresh load.

## Interface
- `ADDR_WIDTH`, default 10: instruction memory word-address width; depth = 2^ADDR_WIDTH words.
- `clk  in  1`: system clock, the same domain as the UART receiver.
- `rst  in  1`: synchronous, active-high reset.
- `rx_update  in  1`: byte toggle from the receiver. Each change of level means one new byte.
- `rx_byte  in  8`: received byte. Valid in the cycle `rx_update` changes, and stable until the next change.
- `mem_we  out  1`: one-cycle instruction-memory write strobe.
- `mem_addr  out  ADDR_WIDTH`: word address of the write.
- `mem_wdata  out  32`: write data.
- `cpu_rst  out  1`: CPU reset request. High while idle-after-reset or loading.
- `done  out  1`: high while in DONE.

## Operation
- Byte strobe: `strobe = rx_update ^ prev_update`. `prev_update` is registered every cycle. On `rst`, `prev_update <= rx_update`, so reset never creates a spurious strobe.
- State machine `loader_state_t`: HDR_LO, HDR_HI, DATA, DONE. Reset state is HDR_LO.
- **HDR_LO**
  - On strobe: `count[7:0] <= rx_byte`; go to HDR_HI.
- **HDR_HI**
  - On strobe: `count[15:8] <= rx_byte`; `addr <= 0`; `byte_idx <= 0`.
  - If the full 16-bit count is 0, go to DONE; otherwise go to DATA.
- **DATA**
  - On strobe: `shift <= {rx_byte, shift[31:8]}`, so the first byte becomes the least significant.
  - `byte_idx` is 2 bits, incremented on each strobe, and wraps after 3.
  - On the strobe with `byte_idx == 3`: register `mem_we <= 1`, `mem_wdata <= {rx_byte, shift[31:8]}`, `mem_addr <= addr`. Then increment `addr`, modulo 2^ADDR_WIDTH; counts larger than the memory depth wrap and overwrite.
  - Decrement `count`. If the decremented value is 0, go to DONE.
- **DONE**
  - `cpu_rst = 0`; `done = 1`.
  - On strobe: re-enter loading with this byte as the count's low byte, i.e. `count[7:0] <= rx_byte` and go to HDR_HI. `cpu_rst` rises the following cycle.
- No strobe means no state change. An incomplete frame waits indefinitely; only `rst` or further bytes move the FSM forward.
- `cpu_rst` and `done` are registered and decoded from the next state, so both are glitch-free.

## Timing
- **Reset values:** `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `cpu_rst=1`, `done=0`. Internal registers: `count=0`, `byte_idx=0`, `addr=0`, `shift=0`.
- **Write latency:** `mem_we` is high exactly one cycle, the cycle after the strobe of a word's 4th byte. `mem_addr`/`mem_wdata` are valid in that cycle and held afterwards.
- **End of load, final word:** `mem_we` of the final word and the `cpu_rst` 1→0 and `done` 0→1 transitions happen in the same cycle, one cycle after the last strobe. Memory is written no later than the CPU's release edge.
- **End of load, count = 0:** `cpu_rst` falls one cycle after the HDR_HI strobe. No write occurs.
- **Back-to-back strobes:** strobes on consecutive cycles must be accepted. The FSM consumes one byte per cycle with no stall, and no backpressure exists.
- **Reset mid-load:** `rst` aborts immediately and returns to HDR_LO. Any partial word is discarded and `mem_we` is 0 the next cycle.
- **Reset and strobe in the same cycle:** the byte is dropped and reset wins.

## Structure
- Package `uart_pkg` contains:
  - `loader_state_t` (enum logic [1:0]);
  - `WORD_BYTES = 4`;
  - `COUNT_WIDTH = 16`.
- Sub-module `toggle_to_pulse` (clk, rst, toggle in, pulse out). It holds the `prev_update` register and XOR, and is reusable for other toggle-handshake consumers.
- The rest is a single always_ff FSM plus datapath registers.

## Test plan
- **Basic load:** send bytes 02 00 78 56 34 12 EF BE AD DE.
  - Expect writes 0x12345678 @0 and 0xDEADBEEF @1, each `mem_we` one cycle wide.
  - `cpu_rst` falls in the same cycle as the second write; `done=1`.
- **Zero count:** send 00 00.
  - Expect no `mem_we`.
  - `cpu_rst` falls one cycle after the second strobe.
- **Reload:** after the basic load completes, send 01 00 11 22 33 44.
  - `cpu_rst` rises one cycle after the first strobe.
  - Expect write 0x44332211 @0, then `done`.
- **Reset mid-word:** send 01 00 AA BB, assert `rst` for 1 cycle, then send 01 00 01 02 03 04.
  - Expect a single write, 0x04030201 @0; AA/BB never appear.
- **Wrap:** with `ADDR_WIDTH=2`, send count 5 (05 00) and five words.
  - Expect addresses 0,1,2,3,0, with the fifth word overwriting address 0.
- **Toggle and reset edge cases:**
  - `rx_update` steady high before and through `rst` produces no strobe.
  - Strobes on consecutive cycles are all captured in order.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART program loader
package uart_pkg;
  typedef enum logic [1:0] {HDR_LO, HDR_HI, DATA, DONE} loader_state_t;
  localparam int WORD_BYTES  = 4;
  localparam int COUNT_WIDTH = 16;
endpackage

// File: rtl/toggle_to_pulse.sv
// toggle_to_pulse: turns a toggle-per-event handshake into a one-cycle pulse
module toggle_to_pulse (
  input  logic clk,
  input  logic rst,
  input  logic toggle,
  output logic pulse
);
  logic prev_q, prev_d;
  // Track the last toggle level; during reset the pulse is masked so it cannot fire
  always_comb begin
    prev_d = toggle;
    pulse  = (toggle ^ prev_q) & ~rst;
  end
  // Reset also loads the current level, so leaving reset never creates an edge
  always_ff @(posedge clk) prev_q <= prev_d;
endmodule

// File: rtl/uart_loader.sv
// uart_loader: frames UART bytes into a word count plus little-endian words written to instruction memory
module uart_loader
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_update,
  input  logic [7:0]            rx_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  done
);
  logic                   strobe;
  loader_state_t          state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [1:0]             idx_q, idx_d;
  logic [31:0]            shift_q, shift_d, mem_wdata_q, mem_wdata_d;
  logic                   mem_we_q, mem_we_d, cpu_rst_q, cpu_rst_d, done_q, done_d;

  toggle_to_pulse u_t2p (.clk(clk), .rst(rst), .toggle(rx_update), .pulse(strobe));

  // Next-state and datapath decode; nothing moves without a byte strobe
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (strobe) begin
      case (state_q)
        HDR_HI: begin
          count_d = {rx_byte, count_q[7:0]};
          addr_d  = '0;
          idx_d   = '0;
          state_d = (count_d == '0) ? DONE : DATA;
        end
        DATA: begin
          shift_d = {rx_byte, shift_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'(WORD_BYTES - 1)) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = shift_d;
            mem_addr_d  = addr_q;
            addr_d      = addr_q + 1'b1;
            count_d     = count_q - 1'b1;
            state_d     = (count_d == '0) ? DONE : DATA;
          end
        end
        default: begin
          count_d = {count_q[COUNT_WIDTH-1:8], rx_byte};
          state_d = HDR_HI;
        end
      endcase
    end
    cpu_rst_d = state_d != DONE;
    done_d    = state_d == DONE;
  end

  // FSM, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR_LO;
      count_q     <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: scoreboard bench for the UART program loader
module tb_uart_loader;
  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_update = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        mem_we, cpu_rst, done;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;

  uart_loader #(.ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .rx_update(rx_update), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte   = b;
    rx_update = ~rx_update;
  endtask

  task automatic expect_wr(input logic [1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we) begin
      wr_t w;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, no write expected at %0t", mem_addr, mem_wdata, $time);
      end else begin
        w = exp_q.pop_front();
        if (mem_addr !== w.addr || mem_wdata !== w.data) begin
          errors++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h at %0t",
                   mem_addr, mem_wdata, w.addr, w.data, $time);
        end
      end
    end
  end

  logic [31:0] wrap_words [5];

  initial begin
    wrap_words = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140};
    repeat (3) @(negedge clk);
    chk("reset_cpu_rst", {31'b0, cpu_rst}, 1);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_we", {31'b0, mem_we}, 0);
    chk("reset_addr", {30'b0, mem_addr}, 0);
    chk("reset_wdata", mem_wdata, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_cpu_rst", {31'b0, cpu_rst}, 1);
    chk("idle_done", {31'b0, done}, 0);

    expect_wr(2'd0, 32'h12345678);
    expect_wr(2'd1, 32'hDEADBEEF);
    foreach (wrap_words[i]) ;
    send(8'h02); send(8'h00); send(8'h78); send(8'h56); send(8'h34);
    send(8'h12); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("basic_pre_cpu_rst", {31'b0, cpu_rst}, 1);
    chk("basic_pre_done", {31'b0, done}, 0);
    @(negedge clk);
    chk("basic_last_we", {31'b0, mem_we}, 1);
    chk("basic_cpu_rst", {31'b0, cpu_rst}, 0);
    chk("basic_done", {31'b0, done}, 1);

    send(8'h01);
    @(negedge clk);
    chk("reload_cpu_rst", {31'b0, cpu_rst}, 1);
    chk("reload_done", {31'b0, done}, 0);
    expect_wr(2'd0, 32'h44332211);
    send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk);
    chk("reload_we", {31'b0, mem_we}, 1);
    chk("reload_end_cpu_rst", {31'b0, cpu_rst}, 0);
    chk("reload_end_done", {31'b0, done}, 1);

    send(8'h00);
    @(negedge clk);
    chk("zero_hdr_cpu_rst", {31'b0, cpu_rst}, 1);
    send(8'h00);
    @(negedge clk);
    chk("zero_cpu_rst", {31'b0, cpu_rst}, 0);
    chk("zero_done", {31'b0, done}, 1);
    chk("zero_we", {31'b0, mem_we}, 0);

    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    @(negedge clk);
    rst       = 1'b1;
    rx_byte   = 8'h55;
    rx_update = ~rx_update;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_we", {31'b0, mem_we}, 0);
    chk("midrst_cpu_rst", {31'b0, cpu_rst}, 1);
    chk("midrst_done", {31'b0, done}, 0);
    expect_wr(2'd0, 32'h04030201);
    send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    @(negedge clk);
    chk("midrst_reload_we", {31'b0, mem_we}, 1);
    chk("midrst_reload_done", {31'b0, done}, 1);

    expect_wr(2'd0, wrap_words[0]);
    expect_wr(2'd1, wrap_words[1]);
    expect_wr(2'd2, wrap_words[2]);
    expect_wr(2'd3, wrap_words[3]);
    expect_wr(2'd0, wrap_words[4]);
    send(8'h05); send(8'h00);
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++)
        send(8'(i * 16 + k));
    @(negedge clk);
    chk("wrap_done", {31'b0, done}, 1);
    chk("wrap_last_addr", {30'b0, mem_addr}, 0);
    repeat (3) @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
